// File: rtl/cart_bank_mapper_if.sv
// CPU-side and DDR3-side toggle handshake bundle for cart_bank_mapper.
// master = mapper (drives cpu_ack, mem_addr, mem_req); slave = its environment.
interface cart_bank_mapper_if #(
  parameter int CPU_W = 22,
  parameter int OUT_W = 25
);
  logic [CPU_W-1:0] cpu_addr;
  logic             cpu_req;
  logic             cpu_ack;
  logic [OUT_W-1:0] mem_addr;
  logic             mem_req;
  logic             mem_ack;

  modport master (
    input  cpu_addr,
    input  cpu_req,
    output cpu_ack,
    output mem_addr,
    output mem_req,
    input  mem_ack
  );

  modport slave (
    output cpu_addr,
    output cpu_req,
    input  cpu_ack,
    input  mem_addr,
    input  mem_req,
    output mem_ack
  );
endinterface

// File: rtl/cart_bank_mapper.sv
// Cartridge bank mapper: page-table translation of CPU ROM requests onto DDR3, toggle handshake.
// Optional SRAM window over bank SRAM_BANK, enabled by defining MAPPER_SRAM_EN.
module cart_bank_mapper #(
  parameter int CPU_W     = 22,
  parameter int OFFS_W    = 19,
  parameter int PAGE_BITS = 6,
  parameter int SRAM_BANK = 4
) (
  input  logic                            clk_sys,
  input  logic                            reset,
  input  logic                            map_we,
  input  logic [CPU_W-OFFS_W-1:0]         map_a,
  input  logic [PAGE_BITS-1:0]            map_d,
  input  logic [PAGE_BITS-1:0]            rom_page_mask,
  cart_bank_mapper_if.master              bus,
  input  logic                            sram_we,
  input  logic [1:0]                      sram_d,
  output logic                            sram_hit,
  output logic                            sram_wp
);
  localparam int BANK_BITS = CPU_W - OFFS_W;
  localparam int OUT_W     = PAGE_BITS + OFFS_W;
  localparam int NBANKS    = 2 ** BANK_BITS;

  typedef enum logic [1:0] {IDLE, WAIT, SACK} state_t;

  state_t                 state;
  logic [PAGE_BITS-1:0]   map_tbl [NBANKS];
  logic                   use_map;
  logic                   cpu_ack_q;
  logic                   mem_req_q;
  logic [OUT_W-1:0]       mem_addr_q;
  logic                   sram_hit_q;

  logic [BANK_BITS-1:0]   bank;
  logic [PAGE_BITS-1:0]   page;
  logic [OUT_W-1:0]       phys;
  logic                   win_hit;

  assign bank = bus.cpu_addr[CPU_W-1:OFFS_W];

  always_comb begin
    page = PAGE_BITS'(bank);
    if (use_map) page = map_tbl[bank];
    phys = {page & rom_page_mask, bus.cpu_addr[OFFS_W-1:0]};
  end

`ifdef MAPPER_SRAM_EN
  logic sram_en;
  logic sram_wp_q;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sram_en   <= 1'b0;
      sram_wp_q <= 1'b0;
    end else if (sram_we) begin
      sram_en   <= sram_d[0];
      sram_wp_q <= sram_d[1];
    end
  end

  assign win_hit = sram_en && (bank == BANK_BITS'(SRAM_BANK));
  assign sram_wp = sram_wp_q;
`else
  logic unused_sram;
  assign unused_sram = ^{sram_we, sram_d};
  assign win_hit     = 1'b0;
  assign sram_wp     = 1'b0;
`endif

  // Table update and request latch share the edge, so a latch in the
  // same cycle as a write sees the old entry.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      for (int i = 0; i < NBANKS; i++) map_tbl[i] <= PAGE_BITS'(i);
      use_map    <= 1'b0;
      state      <= IDLE;
      mem_req_q  <= bus.mem_ack;
      cpu_ack_q  <= bus.cpu_req;
      mem_addr_q <= '0;
      sram_hit_q <= 1'b0;
    end else begin
      if (map_we && (map_a != '0)) begin
        map_tbl[map_a] <= map_d;
        use_map        <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (bus.cpu_req != cpu_ack_q) begin
            mem_addr_q <= phys;
            sram_hit_q <= win_hit;
            if (win_hit) begin
              state <= SACK;
            end else begin
              mem_req_q <= ~mem_req_q;
              state     <= WAIT;
            end
          end
        end
        WAIT: begin
          if (bus.mem_ack == mem_req_q) begin
            cpu_ack_q <= bus.cpu_req;
            state     <= IDLE;
          end
        end
        SACK: begin
          cpu_ack_q <= bus.cpu_req;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cpu_ack  = cpu_ack_q;
  assign bus.mem_req  = mem_req_q;
  assign bus.mem_addr = mem_addr_q;
  assign sram_hit     = sram_hit_q;
endmodule

// File: tb/tb_cart_bank_mapper.sv
// Directed bench for cart_bank_mapper; SRAM-window expectations follow MAPPER_SRAM_EN.
module tb_cart_bank_mapper;
  logic       clk_sys = 1'b0;
  logic       reset;
  logic       map_we;
  logic [2:0] map_a;
  logic [5:0] map_d;
  logic [5:0] rom_page_mask;
  logic       sram_we;
  logic [1:0] sram_d;
  logic       sram_hit;
  logic       sram_wp;

  int checks = 0;
  int errors = 0;
  logic exp_ack  = 1'b0;
  logic exp_mreq = 1'b0;

  cart_bank_mapper_if #(.CPU_W(22), .OUT_W(25)) bus ();

  cart_bank_mapper dut (
    .clk_sys       (clk_sys),
    .reset         (reset),
    .map_we        (map_we),
    .map_a         (map_a),
    .map_d         (map_d),
    .rom_page_mask (rom_page_mask),
    .bus           (bus),
    .sram_we       (sram_we),
    .sram_d        (sram_d),
    .sram_hit      (sram_hit),
    .sram_wp       (sram_wp)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full ROM transaction: latch, 5-cycle DDR3 ack, single cpu_ack toggle.
  task automatic rom_access(input logic [21:0] a, input logic [24:0] exp_a, input string tag);
    bus.cpu_addr = a;
    bus.cpu_req  = ~bus.cpu_req;
    tick();
    exp_mreq = ~exp_mreq;
    check({tag, "_addr"}, 32'(bus.mem_addr), 32'(exp_a));
    check({tag, "_mreq"}, 32'(bus.mem_req), 32'(exp_mreq));
    check({tag, "_shit"}, 32'(sram_hit), 32'd0);
    repeat (4) tick();
    check({tag, "_ack_wait"}, 32'(bus.cpu_ack), 32'(exp_ack));
    bus.mem_ack = exp_mreq;
    tick();
    exp_ack = bus.cpu_req;
    check({tag, "_ack"}, 32'(bus.cpu_ack), 32'(exp_ack));
    tick();
    check({tag, "_ack_once"}, 32'(bus.cpu_ack), 32'(exp_ack));
  endtask

  initial begin
    reset         = 1'b1;
    map_we        = 1'b0;
    map_a         = '0;
    map_d         = '0;
    rom_page_mask = 6'h3F;
    sram_we       = 1'b0;
    sram_d        = 2'b00;
    bus.cpu_addr  = '0;
    bus.cpu_req   = 1'b0;
    bus.mem_ack   = 1'b0;
    tick();
    tick();
    check("rst_cpu_ack", 32'(bus.cpu_ack), 32'd0);
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_sram_hit", 32'(sram_hit), 32'd0);
    check("rst_sram_wp", 32'(sram_wp), 32'd0);
    reset = 1'b0;
    tick();

    rom_access(22'h0A1234, 25'h00A1234, "t1");

    map_we = 1'b1; map_a = 3'd1; map_d = 6'h2A;
    tick();
    map_we = 1'b0;
    rom_access(22'h080010, 25'h1500010, "t2_bank1");
    rom_access(22'h000123, 25'h0000123, "t2_bank0");
    map_we = 1'b1; map_a = 3'd0; map_d = 6'h3F;
    tick();
    map_we = 1'b0;
    rom_access(22'h000123, 25'h0000123, "t2_bank0_fixed");

    map_we = 1'b1; map_a = 3'd2; map_d = 6'h13; rom_page_mask = 6'h0F;
    tick();
    map_we = 1'b0;
    rom_access(22'h100555, 25'h0180555, "t3_mask");
    rom_page_mask = 6'h3F;

    map_we = 1'b1; map_a = 3'd3; map_d = 6'h21;
    bus.cpu_addr = 22'h180007;
    bus.cpu_req  = ~bus.cpu_req;
    tick();
    map_we = 1'b0;
    exp_mreq = ~exp_mreq;
    check("t4_old_page", 32'(bus.mem_addr), 32'h0180007);
    check("t4_mreq", 32'(bus.mem_req), 32'(exp_mreq));
    repeat (2) tick();
    bus.mem_ack = exp_mreq;
    tick();
    exp_ack = bus.cpu_req;
    check("t4_ack", 32'(bus.cpu_ack), 32'(exp_ack));
    tick();
    rom_access(22'h180007, 25'h1080007, "t4_new_page");

    bus.cpu_addr = 22'h080000;
    bus.cpu_req  = ~bus.cpu_req;
    tick();
    exp_mreq = ~exp_mreq;
    check("t5_mreq", 32'(bus.mem_req), 32'(exp_mreq));
    check("t5_addr", 32'(bus.mem_addr), 32'h1500000);
    repeat (2) tick();
    reset       = 1'b1;
    bus.cpu_req = exp_ack;
    tick();
    reset    = 1'b0;
    exp_mreq = bus.mem_ack;
    check("t5_no_ack", 32'(bus.cpu_ack), 32'(exp_ack));
    check("t5_mreq_sync", 32'(bus.mem_req), 32'(exp_mreq));
    check("t5_addr_clr", 32'(bus.mem_addr), 32'd0);
    tick();
    check("t5_idle_ack", 32'(bus.cpu_ack), 32'(exp_ack));
    check("t5_idle_mreq", 32'(bus.mem_req), 32'(exp_mreq));
    rom_access(22'h080040, 25'h0080040, "t5_identity");

    sram_we = 1'b1; sram_d = 2'b11;
    tick();
    sram_we = 1'b0;
`ifdef MAPPER_SRAM_EN
    check("t6_wp", 32'(sram_wp), 32'd1);
    bus.cpu_addr = 22'h200099;
    bus.cpu_req  = ~bus.cpu_req;
    tick();
    check("t6_hit", 32'(sram_hit), 32'd1);
    check("t6_no_mreq", 32'(bus.mem_req), 32'(exp_mreq));
    check("t6_ack_early", 32'(bus.cpu_ack), 32'(exp_ack));
    tick();
    exp_ack = bus.cpu_req;
    check("t6_ack", 32'(bus.cpu_ack), 32'(exp_ack));
    check("t6_no_mreq2", 32'(bus.mem_req), 32'(exp_mreq));
    tick();
    check("t6_ack_once", 32'(bus.cpu_ack), 32'(exp_ack));
    rom_access(22'h300099, 25'h0300099, "t6_bank6_rom");
`else
    check("t6_wp", 32'(sram_wp), 32'd0);
    rom_access(22'h200099, 25'h0200099, "t6_rom");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
